// File: rtl/ysyx_imem_resp.sv
// Instruction-memory responder: one outstanding IFU word read, answered after a programmable latency.
// Optional YSYX_IMEM_RAND_DELAY_EN adds an LFSR-driven 0..7 cycle extra latency per request.
module ysyx_imem_resp #(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 32,
  parameter int                DEPTH_W = 10,
  parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000,
  parameter int                LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  ifu_araddr,
  input  logic               ifu_arvalid,
  output logic [DATA_W-1:0]  ifu_rdata,
  output logic               ifu_rvalid,
  output logic               ifu_rerr,
  output logic               busy,
  input  logic               wen,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int             CNT_W  = 5;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s, cnt_load_s;
  logic [ADDR_W-1:2]   addr_r, addr_s;
  logic [DATA_W-1:0]   rdata_r, rdata_s;
  logic                rerr_r, rerr_s;
  logic                rvalid_r, rvalid_s;
  logic                busy_r, busy_s;
  logic                hit_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic                unused_s;

  logic [DATA_W-1:0]   mem [2**DEPTH_W];

  // Byte offset within a word carries no information for word fetches.
  assign unused_s  = ^ifu_araddr[1:0];
  assign hit_s     = (addr_r[ADDR_W-1:DEPTH_W+2] == BASE[ADDR_W-1:DEPTH_W+2]);
  assign rd_word_s = mem[addr_r[DEPTH_W+1:2]];

`ifdef YSYX_IMEM_RAND_DELAY_EN
  logic [7:0] lfsr_r, lfsr_s;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  assign cnt_load_s = LAT_M1 + {2'b00, lfsr_r[2:0]};
`else
  assign cnt_load_s = LAT_M1;
`endif

  // Preload write port; not reset, and a write on the response edge is not seen by that read.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  // Next-state and next-output logic for the request FSM.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    addr_s   = addr_r;
    rdata_s  = rdata_r;
    rerr_s   = 1'b0;
    rvalid_s = 1'b0;
`ifdef YSYX_IMEM_RAND_DELAY_EN
    lfsr_s   = lfsr_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (ifu_arvalid) begin
          state_s = S_WAIT;
          addr_s  = ifu_araddr[ADDR_W-1:2];
          cnt_s   = cnt_load_s;
`ifdef YSYX_IMEM_RAND_DELAY_EN
          lfsr_s  = lfsr_step(lfsr_r);
`endif
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_s  = S_RESP;
          rvalid_s = 1'b1;
          rdata_s  = hit_s ? rd_word_s : {DATA_W{1'b0}};
          rerr_s   = ~hit_s;
        end
      end
      S_RESP: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    busy_s = (state_s != S_IDLE);
  end

  // State and registered outputs; async reset drops any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= S_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      addr_r   <= {(ADDR_W-2){1'b0}};
      rdata_r  <= {DATA_W{1'b0}};
      rerr_r   <= 1'b0;
      rvalid_r <= 1'b0;
      busy_r   <= 1'b0;
`ifdef YSYX_IMEM_RAND_DELAY_EN
      lfsr_r   <= 8'hA5;
`endif
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      addr_r   <= addr_s;
      rdata_r  <= rdata_s;
      rerr_r   <= rerr_s;
      rvalid_r <= rvalid_s;
      busy_r   <= busy_s;
`ifdef YSYX_IMEM_RAND_DELAY_EN
      lfsr_r   <= lfsr_s;
`endif
    end
  end

  assign ifu_rdata  = rdata_r;
  assign ifu_rvalid = rvalid_r;
  assign ifu_rerr   = rerr_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_ysyx_imem_resp.sv
// Directed bench for ysyx_imem_resp: one instance at LATENCY=2, one at LATENCY=1 for throughput.
module tb_ysyx_imem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ar0, ar1, rd0, rd1;
  logic        av0, av1, rv0, rv1, re0, re1, busy0, busy1;
  logic        wen;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  lf0 = 8'hA5;
  logic [7:0]  lf1 = 8'hA5;

  always #5 clk = ~clk;

  ysyx_imem_resp #(.LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst), .ifu_araddr(ar0), .ifu_arvalid(av0), .ifu_rdata(rd0),
    .ifu_rvalid(rv0), .ifu_rerr(re0), .busy(busy0), .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  ysyx_imem_resp #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .ifu_araddr(ar1), .ifu_arvalid(av1), .ifu_rdata(rd1),
    .ifu_rvalid(rv1), .ifu_rerr(re1), .busy(busy1), .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Expected latency of the next accepted request on each instance.
  task automatic next_lat0(output int lat);
`ifdef YSYX_IMEM_RAND_DELAY_EN
    lat = 2 + int'(lf0[2:0]);
    lf0 = lfsr_step(lf0);
`else
    lat = 2;
`endif
  endtask

  task automatic next_lat1(output int lat);
`ifdef YSYX_IMEM_RAND_DELAY_EN
    lat = 1 + int'(lf1[2:0]);
    lf1 = lfsr_step(lf1);
`else
    lat = 1;
`endif
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    wen = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic req0(input string tag, input logic [31:0] a, input logic [31:0] ed, input logic ee);
    int lat;
    int cyc;
    @(negedge clk);
    av0 = 1'b1; ar0 = a;
    next_lat0(lat);
    @(negedge clk);
    av0 = 1'b0; ar0 = 32'h0000_0000;
    check({tag, "_busy"}, busy0, 1);
    cyc = 0;
    while (rv0 !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, cyc, lat);
`ifdef YSYX_IMEM_RAND_DELAY_EN
    check({tag, "_lat_rng"}, (cyc >= 2 && cyc <= 9), 1);
`endif
    check({tag, "_data"}, rd0, ed);
    check({tag, "_err"}, re0, ee);
    @(negedge clk);
    check({tag, "_pulse"}, rv0, 0);
    check({tag, "_idle"}, busy0, 0);
    check({tag, "_hold"}, rd0, ed);
    check({tag, "_errclr"}, re0, 0);
  endtask

  initial begin
    int lat;
    int t;
    int exp_t;
    int nl;
    int pulses;
    rst = 1'b0; av0 = 1'b0; av1 = 1'b0; ar0 = '0; ar1 = '0;
    wen = 1'b0; waddr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_rvalid", rv0, 0);
    check("rst_rerr", re0, 0);
    check("rst_rdata", rd0, 0);
    check("rst_busy", busy0, 0);
    rst = 1'b1;

    preload(10'd5, 32'hDEAD_BEEF);
    preload(10'd0, 32'h0000_0000);
    req0("hit", 32'h8000_0014, 32'hDEAD_BEEF, 1'b0);
    req0("miss", 32'h0000_0100, 32'h0000_0000, 1'b1);

    // Write 1 on the early WAIT edges, 2 on the WAIT->RESP edge; the read returns 1.
    @(negedge clk);
    av0 = 1'b1; ar0 = 32'h8000_0000;
    next_lat0(lat);
    @(negedge clk);
    av0 = 1'b0; wen = 1'b1; waddr = 10'd0; wdata = 32'd1;
    for (int i = 0; i < lat - 2; i++) @(negedge clk);
    @(negedge clk);
    wdata = 32'd2;
    @(negedge clk);
    wen = 1'b0;
    check("coll_rvalid", rv0, 1);
    check("coll_data", rd0, 32'd1);
    req0("after_coll", 32'h8000_0000, 32'd2, 1'b0);

    // Held request on the LATENCY=1 instance; address disturbed during the first WAIT.
    @(negedge clk);
    av1 = 1'b1; ar1 = 32'h8000_0000;
    next_lat1(nl);
    exp_t = nl + 1; t = 0; pulses = 0;
    while (pulses < 3 && t < 100) begin
      @(negedge clk);
      t++;
      if (t == 1) ar1 = 32'h0000_0100;
      if (rv1 === 1'b1) begin
        check("tp_time", t, exp_t);
        check("tp_data", rd1, 32'd2);
        check("tp_err", re1, 0);
        pulses++;
        ar1 = 32'h8000_0000;
        if (pulses < 3) begin
          next_lat1(nl);
          exp_t = t + nl + 2;
        end
      end
    end
    av1 = 1'b0;
    check("tp_count", pulses, 3);
    repeat (2) @(negedge clk);

    // Reset during WAIT drops the request.
    @(negedge clk);
    av0 = 1'b1; ar0 = 32'h8000_0014;
    @(negedge clk);
    av0 = 1'b0;
    check("mid_busy", busy0, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_rvalid", rv0, 0);
    lf0 = 8'hA5; lf1 = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_quiet", rv0, 0);
    end
    rst = 1'b1;
    req0("post_rst", 32'h8000_0014, 32'hDEAD_BEEF, 1'b0);

    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 1) req0("seq_a", 32'h8000_0014, 32'hDEAD_BEEF, 1'b0);
      else            req0("seq_b", 32'h8000_0000, 32'd2, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
